// File: rtl/acq_pkg.sv
// Shared types and default widths for the acquisition trigger controller.
package acq_pkg;

    localparam int unsigned AcqAw = 14;
    localparam int unsigned AcqDw = 14;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPretrig = 2'd1,
        StArmed   = 2'd2,
        StCapture = 2'd3
    } acq_state_e;

endpackage

// File: rtl/acq_trigger_ctrl.sv
// Pre/post-trigger acquisition sequencer writing ADC samples into a circular capture RAM.
// Build option ACQ_TRIG_EDGE_EN: trigger on a rising edge of trig_in instead of its level.
module acq_trigger_ctrl
    import acq_pkg::*;
#(
    parameter int unsigned AW = AcqAw,
    parameter int unsigned DW = AcqDw
) (
    input  logic          adc_clk,
    input  logic          adc_rstn,
    input  logic          arm,
    input  logic          abort,
    input  logic          trig_in,
    input  logic [DW-1:0] adc_dat_a,
    input  logic [AW-1:0] pretrig_len,
    input  logic [AW-1:0] posttrig_len,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] trig_addr,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state
);

    localparam logic [AW-1:0] One = AW'(1);

    acq_state_e    state_q, state_d;
    logic [AW-1:0] pre_len_q, pre_len_d;
    logic [AW-1:0] post_len_q, post_len_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] trig_addr_q, trig_addr_d;
    logic [DW-1:0] wr_data_q;
    logic          wr_en_q, wr_en_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          trig_hit;

`ifdef ACQ_TRIG_EDGE_EN
    logic trig_q;

    // Tracks trig_in in every state so a level held across arm never looks like an edge.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_in;
        end
    end

    assign trig_hit = trig_in & ~trig_q;
`else
    assign trig_hit = trig_in;
`endif

    always_comb begin
        state_d     = state_q;
        pre_len_d   = pre_len_q;
        post_len_d  = post_len_q;
        cnt_d       = cnt_q;
        trig_addr_d = trig_addr_q;
        wr_en_d     = 1'b0;
        done_d      = 1'b0;
        // The address register always shows the next free slot once a write has retired.
        wr_addr_d   = wr_en_q ? wr_addr_q + One : wr_addr_q;

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm) begin
                        pre_len_d  = pretrig_len;
                        post_len_d = posttrig_len;
                        cnt_d      = '0;
                        state_d    = (pretrig_len == '0) ? StArmed : StPretrig;
                    end
                end
                StPretrig: begin
                    wr_en_d = 1'b1;
                    cnt_d   = cnt_q + One;
                    if (cnt_q + One == pre_len_q) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    wr_en_d = 1'b1;
                    if (trig_hit) begin
                        trig_addr_d = wr_addr_d;
                        cnt_d       = post_len_q;
                        state_d     = StCapture;
                    end
                end
                StCapture: begin
                    if (cnt_q != '0) begin
                        wr_en_d = 1'b1;
                        cnt_d   = cnt_q - One;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            state_q     <= StIdle;
            pre_len_q   <= '0;
            post_len_q  <= '0;
            cnt_q       <= '0;
            wr_addr_q   <= '0;
            trig_addr_q <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_len_q   <= pre_len_d;
            post_len_q  <= post_len_d;
            cnt_q       <= cnt_d;
            wr_addr_q   <= wr_addr_d;
            trig_addr_q <= trig_addr_d;
            wr_data_q   <= adc_dat_a;
            wr_en_q     <= wr_en_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign trig_addr = trig_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule
